// File: rtl/w0rm_core_pipe_buffer.sv
// W0RM core inter-stage elastic buffer: valid/ready FIFO with payload and sideband.
// Define W0RM_PIPE_FLUSH_EN to add the branch-squash flush_i port.
module w0rm_core_pipe_buffer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int USER_WIDTH = 7,
    parameter  int DEPTH      = 2,
    localparam int PTR_BITS   = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [USER_WIDTH-1:0] in_user_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [USER_WIDTH-1:0] out_user_o,
`ifdef W0RM_PIPE_FLUSH_EN
    input  logic                  flush_i,
`endif
    output logic [PTR_BITS:0]     count_o
);

    localparam int              EW       = DATA_WIDTH + USER_WIDTH;
    localparam logic [PTR_BITS:0] CNT_FULL = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0] CNT_ONE  = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);

    logic [EW-1:0]       mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q, count_d;
    logic                push, pop, flush_w;

`ifdef W0RM_PIPE_FLUSH_EN
    assign flush_w = flush_i;
`else
    assign flush_w = 1'b0;
`endif

    // Handshake flags depend only on the occupancy register.
    assign in_ready_o  = (count_q != CNT_FULL);
    assign out_valid_o = (count_q != '0);

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; unoccupied slots are never observable.
    always_ff @(posedge clk_i) begin
        if (push && !flush_w && !reset_i) begin
            mem_q[wr_ptr_q] <= {in_data_i, in_user_i};
        end
    end

    always_comb begin
        out_data_o = '0;
        out_user_o = '0;
        if (out_valid_o) begin
            {out_data_o, out_user_o} = mem_q[rd_ptr_q];
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_w0rm_core_pipe_buffer.sv
// Randomized + directed bench for w0rm_core_pipe_buffer against a queue model.
// Flush cases are exercised only when W0RM_PIPE_FLUSH_EN is defined.
module tb_w0rm_core_pipe_buffer;

    localparam int DW    = 32;
    localparam int UW    = 7;
    localparam int DEPTH = 4;
    localparam int PB    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [UW-1:0] in_user;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [UW-1:0] out_user;
    logic [PB:0]   count;
    logic          flush;

    int n_vec = 0;
    int n_err = 0;

    logic [DW+UW-1:0] mq [$];

    always #5 clk = ~clk;

    w0rm_core_pipe_buffer #(
        .DATA_WIDTH(DW),
        .USER_WIDTH(UW),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_data_i(in_data),
        .in_user_i(in_user),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o(out_data),
        .out_user_o(out_user),
`ifdef W0RM_PIPE_FLUSH_EN
        .flush_i(flush),
`endif
        .count_o(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [DW+UW-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        chk("count", 64'(count), 64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        chk("out_data", 64'(out_data), 64'(head[DW+UW-1:UW]));
        chk("out_user", 64'(out_user), 64'(head[UW-1:0]));
    endtask

    // Drive one cycle's inputs, advance the model, then check after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d,
                         input logic [UW-1:0] u, input logic ordy,
                         input logic fl, input logic rst);
        bit do_push, do_pop, fl_eff;
        in_valid  = v;
        in_data   = d;
        in_user   = u;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
`ifdef W0RM_PIPE_FLUSH_EN
        fl_eff = fl;
`else
        fl_eff = 1'b0;
`endif
        do_push = v && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        if (rst || fl_eff) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({d, u});
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [DW-1:0] fill [4];
        fill = '{32'h11, 32'h22, 32'h33, 32'h44};
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_user = '0;
        out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Reset held two cycles with in_valid asserted.
        cycle(1'b1, 32'hDEAD, 7'h5, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hBEEF, 7'h6, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_oval", 64'(out_valid), 64'd0);
        chk("rst_odata", 64'(out_data), 64'd0);
        chk("rst_irdy", 64'(in_ready), 64'd1);

        // Fill, then a refused fifth push.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, fill[i], 7'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 7'h7F, 1'b0, 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_irdy", 64'(in_ready), 64'd0);
        chk("full_head", 64'(out_data), 64'h11);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 64'(out_data), 64'(fill[i]));
            cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_oval", 64'(out_valid), 64'd0);
        chk("drain_count", 64'(count), 64'd0);

        // Streaming across pointer wrap.
        cycle(1'b1, 32'h0, 7'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            chk("wrap_count", 64'(count), 64'd1);
            chk("wrap_data", 64'(out_data), 64'(i - 1));
            cycle(1'b1, 32'(i), 7'(i), 1'b1, 1'b0, 1'b0);
        end
        chk("wrap_last", 64'(out_data), 64'd9);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Full plus same-cycle pop: push refused, one slot frees.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'hA0 + 32'(i), 7'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h66, 7'h1, 1'b1, 1'b0, 1'b0);
        chk("fp_count", 64'(count), 64'd3);
        chk("fp_irdy", 64'(in_ready), 64'd1);
        chk("fp_head", 64'(out_data), 64'hA1);

`ifdef W0RM_PIPE_FLUSH_EN
        cycle(1'b1, 32'hAA, 7'h2, 1'b0, 1'b1, 1'b0);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_oval", 64'(out_valid), 64'd0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("fl_gone", 64'(out_valid), 64'd0);
`else
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
`endif

        // Random traffic with occasional reset/flush.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom(),
                  7'($urandom()), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0),
                  1'($urandom_range(0, 80) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
